// File: rtl/ram_arbiter_if.sv
// Requester-side access port of the shared-RAM arbiter: request/grant handshake plus read return.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 7
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-way round-robin arbiter and clear engine in front of a 1W/1R synchronous RAM;
// read data comes back one cycle late and is tagged to the requester that issued it.
module ram_arbiter #(
  parameter int                    ADDR_WIDTH  = 13,
  parameter int                    DATA_WIDTH  = 7,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          req0_if,
  ram_arbiter_if.slave          req1_if,
  input  logic                  clear_start_i,
  output logic                  busy_o,
  output logic                  clear_done_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_w_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_r_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_e                state_q;
  logic                  prio_q;
  logic                  rvalid0_q, rvalid1_q;
  logic                  busy_q, clear_done_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_w_q, addr_r_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic                  gnt0, gnt1;
  logic                  gnt_we;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  ram_we_d;
  logic [ADDR_WIDTH-1:0] addr_w_d, addr_r_d;
  logic [DATA_WIDTH-1:0] din_d;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_we_d  = 1'b0;
    addr_w_d  = addr_w_q;
    addr_r_d  = addr_r_q;
    din_d     = din_q;

    if (!rst && state_q == IDLE) begin
      gnt0 = req0_if.req && (!req1_if.req || !prio_q);
      gnt1 = req1_if.req && (!req0_if.req ||  prio_q);
    end

    gnt_we    = gnt0 ? req0_if.we    : req1_if.we;
    gnt_addr  = gnt0 ? req0_if.addr  : req1_if.addr;
    gnt_wdata = gnt0 ? req0_if.wdata : req1_if.wdata;

    if (!rst && state_q == CLEAR) begin
      ram_we_d = 1'b1;
      addr_w_d = cnt_q;
      din_d    = CLEAR_VALUE;
    end else if (gnt0 || gnt1) begin
      if (gnt_we) begin
        ram_we_d = 1'b1;
        addr_w_d = gnt_addr;
        din_d    = gnt_wdata;
      end else begin
        addr_r_d = gnt_addr;
      end
    end
  end

  // Address/data registers only remember the last driven value so idle cycles replay it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      addr_w_q     <= '0;
      addr_r_q     <= '0;
      din_q        <= '0;
    end else begin
      addr_w_q     <= addr_w_d;
      addr_r_q     <= addr_r_d;
      din_q        <= din_d;
      rvalid0_q    <= gnt0 && !req0_if.we;
      rvalid1_q    <= gnt1 && !req1_if.we;
      clear_done_q <= 1'b0;

      if (gnt0)      prio_q <= 1'b1;
      else if (gnt1) prio_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (clear_start_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_if.gnt    = gnt0;
  assign req1_if.gnt    = gnt1;
  assign req0_if.rvalid = rvalid0_q;
  assign req1_if.rvalid = rvalid1_q;
  assign req0_if.rdata  = ram_dout_i;
  assign req1_if.rdata  = ram_dout_i;

  assign busy_o       = busy_q;
  assign clear_done_o = clear_done_q;
  assign ram_we_o     = ram_we_d;
  assign ram_addr_w_o = addr_w_d;
  assign ram_addr_r_o = addr_r_d;
  assign ram_din_o    = din_d;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small 8-word behavioural RAM attached.
module tb_ram_arbiter;
  localparam int AW = 3;
  localparam int DW = 7;
  localparam logic [DW-1:0] CV = 7'h11;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_start;
  logic          busy, clear_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] mem [2**AW];

  int checks = 0;
  int errors = 0;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_if      (r0_if),
    .req1_if      (r1_if),
    .clear_start_i(clear_start),
    .busy_o       (busy),
    .clear_done_o (clear_done),
    .ram_we_o     (ram_we),
    .ram_addr_w_o (ram_addr_w),
    .ram_addr_r_o (ram_addr_r),
    .ram_din_o    (ram_din),
    .ram_dout_i   (ram_dout)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= ram_din;
    ram_dout <= mem[ram_addr_r];
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear_start = 1'b0;
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 3'd1; r0_if.wdata = '0;
    r1_if.req = 1'b1; r1_if.we = 1'b0; r1_if.addr = 3'd2; r1_if.wdata = '0;

    // Reset held two cycles with both requesters active
    tick();
    check("rst_gnt0", r0_if.gnt, 0);
    check("rst_gnt1", r1_if.gnt, 0);
    check("rst_rvalid0", r0_if.rvalid, 0);
    check("rst_rvalid1", r1_if.rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_clear_done", clear_done, 0);
    tick();
    check("rst2_gnt0", r0_if.gnt, 0);

    // First contended access goes to requester 0, then requester 1
    rst = 1'b0;
    r0_if.we = 1'b1; r0_if.addr = 3'd1; r0_if.wdata = 7'h0A;
    r1_if.we = 1'b1; r1_if.addr = 3'd2; r1_if.wdata = 7'h14;
    #1;
    check("first_gnt0", r0_if.gnt, 1);
    check("first_gnt1", r1_if.gnt, 0);
    check("first_we", ram_we, 1);
    check("first_addr_w", ram_addr_w, 1);
    check("first_din", ram_din, 7'h0A);
    tick();
    r0_if.req = 1'b0; #1;
    check("second_gnt1", r1_if.gnt, 1);
    check("second_gnt0", r0_if.gnt, 0);
    check("second_addr_w", ram_addr_w, 2);
    check("second_din", ram_din, 7'h14);
    tick();
    r1_if.req = 1'b0; #1;
    check("idle_we", ram_we, 0);
    check("idle_addr_w_hold", ram_addr_w, 2);

    // Single client: write then read addr 5
    r0_if.req = 1'b1; r0_if.we = 1'b1; r0_if.addr = 3'd5; r0_if.wdata = 7'h2A; #1;
    check("sc_wr_gnt0", r0_if.gnt, 1);
    check("sc_wr_we", ram_we, 1);
    tick();
    r0_if.we = 1'b0; #1;
    check("sc_rd_gnt0", r0_if.gnt, 1);
    check("sc_rd_we", ram_we, 0);
    check("sc_rd_addr_r", ram_addr_r, 5);
    tick();
    r0_if.req = 1'b0; #1;
    check("sc_rvalid0", r0_if.rvalid, 1);
    check("sc_rdata0", r0_if.rdata, 7'h2A);
    check("sc_rvalid1", r1_if.rvalid, 0);

    // Requester 1 writes addr 6; pointer ends back at requester 0
    r1_if.req = 1'b1; r1_if.we = 1'b1; r1_if.addr = 3'd6; r1_if.wdata = 7'h33; #1;
    check("r1_wr_gnt1", r1_if.gnt, 1);
    tick();
    r1_if.req = 1'b0;

    // Continuous contention: reads of addr 1 (0x0A) and addr 2 (0x14)
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 3'd1;
    r1_if.req = 1'b1; r1_if.we = 1'b0; r1_if.addr = 3'd2;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cont_gnt0_%0d", i), r0_if.gnt, (i % 2 == 0) ? 1 : 0);
      check($sformatf("cont_gnt1_%0d", i), r1_if.gnt, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("cont_rvalid0_%0d", i), r0_if.rvalid, (i % 2 == 0) ? 1 : 0);
      check($sformatf("cont_rvalid1_%0d", i), r1_if.rvalid, (i % 2 == 1) ? 1 : 0);
      check($sformatf("cont_rdata_%0d", i), ram_dout, (i % 2 == 0) ? 7'h0A : 7'h14);
    end
    r0_if.req = 1'b0; r1_if.req = 1'b0;

    // Read of addr 6 granted in the clear_start cycle
    r0_if.req = 1'b1; r0_if.addr = 3'd6; clear_start = 1'b1; #1;
    check("bnd_gnt0", r0_if.gnt, 1);
    tick();
    clear_start = 1'b0; r0_if.req = 1'b0;
    r1_if.req = 1'b1; r1_if.we = 1'b0; r1_if.addr = 3'd2; #1;
    check("bnd_rvalid0", r0_if.rvalid, 1);
    check("bnd_rdata0", r0_if.rdata, 7'h33);

    // Full clear, with a second clear_start pulse mid-way
    for (int k = 0; k < 8; k++) begin
      check($sformatf("clr_busy_%0d", k), busy, 1);
      check($sformatf("clr_gnt1_%0d", k), r1_if.gnt, 0);
      check($sformatf("clr_we_%0d", k), ram_we, 1);
      check($sformatf("clr_addr_w_%0d", k), ram_addr_w, k);
      check($sformatf("clr_din_%0d", k), ram_din, CV);
      check($sformatf("clr_done_low_%0d", k), clear_done, 0);
      clear_start = (k == 3);
      tick();
    end
    clear_start = 1'b0; #1;
    check("clr_end_busy", busy, 0);
    check("clr_done_pulse", clear_done, 1);
    check("clr_end_gnt1", r1_if.gnt, 1);
    tick();
    r1_if.req = 1'b0; #1;
    check("clr_done_fall", clear_done, 0);
    check("clr_rd_rvalid1", r1_if.rvalid, 1);
    check("clr_rd_rdata1", r1_if.rdata, CV);
    tick();
    check("clr_no_restart", busy, 0);

    // Every address reads back CLEAR_VALUE
    r0_if.req = 1'b1; r0_if.we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      r0_if.addr = AW'(a); #1;
      check($sformatf("rb_gnt0_%0d", a), r0_if.gnt, 1);
      tick();
      check($sformatf("rb_rvalid0_%0d", a), r0_if.rvalid, 1);
      check($sformatf("rb_rdata0_%0d", a), r0_if.rdata, CV);
    end
    r0_if.req = 1'b0;

    // Fill with 0x40+a, then interrupt a clear after four writes
    r0_if.req = 1'b1; r0_if.we = 1'b1;
    for (int a = 0; a < 8; a++) begin
      r0_if.addr = AW'(a); r0_if.wdata = DW'(7'h40 + a); #1;
      check($sformatf("fill_gnt0_%0d", a), r0_if.gnt, 1);
      tick();
    end
    r0_if.req = 1'b0; r0_if.we = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1; #1;
    check("mid_rst_we", ram_we, 0);
    tick();
    rst = 1'b0; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", clear_done, 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("mid_no_done_%0d", j), clear_done, 0);
    end

    r0_if.req = 1'b1; r0_if.we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      r0_if.addr = AW'(a);
      tick();
      check($sformatf("mid_rdata_%0d", a), r0_if.rdata, (a < 4) ? 32'(CV) : 32'(7'h40 + a));
    end
    r0_if.req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and two-way arbiter for the shared synchronous RAM (one write port, one registered read port). It gives two requesters one-access-per-cycle round-robin access and routes the one-cycle-late read data back to whichever requester issued the read. It also contains a clear engine that sweeps the whole RAM with a constant value. It sits between the RAM instance and its clients, for example a frame-buffer updater and a readout or scan client.

## Interface
- ADDR_WIDTH, 13, RAM address bits; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 7, RAM word width.
- CLEAR_VALUE, 0, word written to every address by the clear engine.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  ADDR_WIDTH  access address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  combinational grant; access completes on the edge where req&gnt=1.
- rvalid0 / rvalid1  out  1  registered one-cycle pulse; read data valid.
- rdata0 / rdata1  out  DATA_WIDTH  read data; equals ram_dout, meaningful only while the matching rvalid is high.
- clear_start  in  1  start a full-RAM clear.
- busy  out  1  clear engine active.
- clear_done  out  1  one-cycle pulse after the last clear write.
- ram_we  out  1  to RAM we.
- ram_addr_w  out  ADDR_WIDTH  to RAM addr_w.
- ram_addr_r  out  ADDR_WIDTH  to RAM addr_r.
- ram_din  out  DATA_WIDTH  to RAM din.
- ram_dout  in  DATA_WIDTH  from RAM dout (registered in RAM, 1-cycle latency).

## Operation
- FSM states: IDLE and CLEAR. Reset state is IDLE.
- **IDLE:** at most one grant per cycle.
  - Round-robin pointer `prio` selects the winner when both requesters are active.
  - A lone requester is granted regardless of `prio`.
  - After any grant, `prio` points to the other requester. With no grant, `prio` holds.
- **Granted write:** ram_we=1, ram_addr_w=addrN, ram_din=wdataN.
- **Granted read:** ram_we=0 and ram_addr_r=addrN. A registered owner tag records N, and rvalidN=1 on the next cycle.
- **No grant:** ram_we=0. ram_addr_r and ram_addr_w hold their last driven value, so there are no spurious writes.
- **CLEAR entry:** clear_start sampled high in IDLE moves to CLEAR on the next edge.
  - Requests in the clear_start cycle are still granted normally.
  - clear_start is ignored in CLEAR.
- **CLEAR:** busy=1 and gnt0=gnt1=0.
  - Address counter runs 0 to 2**ADDR_WIDTH-1, one write per cycle: ram_we=1, ram_addr_w=counter, ram_din=CLEAR_VALUE.
  - After the write to the last address, the FSM returns to IDLE, clear_done=1 for one cycle, and the counter is zeroed.
  - A read granted in the cycle before CLEAR still produces its rvalid in the first CLEAR cycle.
- **Arithmetic:** the counter is ADDR_WIDTH+0 bits. Termination compares against the all-ones value, with no wrap-around beyond it.
- **Reset (including mid-clear):**
  - State returns to IDLE, counter=0, prio=0 (requester 0 first).
  - rvalid0=rvalid1=0, busy=0, clear_done=0, ram_we=0, gnt0=gnt1=0.
  - RAM contents are not altered by reset; an interrupted clear leaves a partially cleared RAM.
- **Read/write hazard:** only one access per cycle, so there is no same-cycle collision. A read in cycle t+1 of an address written in cycle t returns the new data.

## Timing
- Grant latency: 0 cycles; gnt is combinational from req, state and prio.
- Requesters hold req/we/addr/wdata stable until the edge with gnt high.
- Read latency: the request is granted at edge t, and rvalid/rdata are valid during cycle t+1. Back-to-back reads give rvalid every cycle.
- Write takes effect at the granting edge.
- Clear duration: exactly 2**ADDR_WIDTH cycles with busy=1.
  - busy rises on the edge after clear_start.
  - busy and clear_done switch on the same edge: busy falls and clear_done rises together.
  - clear_done falls one edge later.
- Sustained throughput: one access per cycle total. Under continuous contention each requester is granted every second cycle.

## Test plan
- **Reset:** hold rst 2 cycles with req0=req1=1 -> gnt0=gnt1=0, rvalid0=rvalid1=0, busy=0, ram_we=0. After release, the first contended grant goes to requester 0.
- **Single client:** req0 write addr 5 data 7'h2A, then read addr 5 -> gnt0 same cycle each time. The cycle after the read grant has rvalid0=1, rdata0=7'h2A, rvalid1=0.
- **Contention:** req0 and req1 both held high reading addrs 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1. rvalid pulses alternate one cycle behind, with correct data per owner.
- **Clear:** ADDR_WIDTH=3, CLEAR_VALUE=7'h11 -> busy high for exactly 8 cycles, ram_addr_w 0..7, no grants despite req1=1. clear_done pulses once; a subsequent read of every address returns 7'h11.
- **Reset mid-clear:** ADDR_WIDTH=3, assert rst after 4 clear cycles -> busy=0 next cycle and clear_done never pulses. Addrs 0..3 read CLEAR_VALUE; addrs 4..7 keep their prior data.
- **Boundary:** clear_start in the same cycle as a granted read of addr 6 -> the read completes with rvalid in the first CLEAR cycle. clear_start pulsed again mid-clear -> clear length is still 8 cycles.
